// File: rtl/axi_tdd_ng_core.sv
// axi_tdd_ng_core: generic TDD timing engine. One frame counter drives an array of
// on/off channel windows, with sync arming, start-up delay, burst control and resync.
module axi_tdd_ng_core #(
  parameter int CHANNEL_COUNT  = 8,
  parameter int REGISTER_WIDTH = 32,
  parameter int BURST_WIDTH    = 32
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     tdd_enable,
  input  logic                                     tdd_sync_ext_en,
  input  logic                                     tdd_sync_ext,
  input  logic                                     tdd_sync_soft,
  input  logic                                     tdd_sync_rst,
  input  logic [REGISTER_WIDTH-1:0]                tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]                tdd_frame_length,
  input  logic [BURST_WIDTH-1:0]                   tdd_burst_count,
  input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_en,
  input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_pol,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_on,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_off,
  output logic [CHANNEL_COUNT-1:0]                 tdd_channel,
  output logic [1:0]                               tdd_cstate,
  output logic [REGISTER_WIDTH-1:0]                tdd_counter,
  output logic                                     tdd_endof_frame
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_WAITING = 2'd2,
    ST_RUNNING = 2'd3
  } state_t;

  state_t                    state, state_next;
  logic [REGISTER_WIDTH-1:0] counter, counter_next;
  logic [REGISTER_WIDTH-1:0] delay_cnt, delay_cnt_next;
  logic [BURST_WIDTH-1:0]    frames, frames_next;
  logic [CHANNEL_COUNT-1:0]  ch_state, ch_state_next, ch_match;
  logic                      sync_ext_d;
  logic                      trig;
  logic                      last_cycle;

  assign trig       = tdd_sync_soft | (tdd_sync_ext_en & tdd_sync_ext & ~sync_ext_d);
  assign last_cycle = (counter == tdd_frame_length);
  assign tdd_cstate  = state;
  assign tdd_counter = counter;

  // Per-channel window update for the current counter value; a clear point wins over a set point.
  always_comb begin
    ch_match = ch_state;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (counter == tdd_channel_off[i*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
        ch_match[i] = 1'b0;
      end else if (counter == tdd_channel_on[i*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
        ch_match[i] = 1'b1;
      end
    end
  end

  // Next-state logic: arming, start-up delay, frame counting, burst end and resync.
  always_comb begin
    state_next     = state;
    counter_next   = counter;
    delay_cnt_next = delay_cnt;
    frames_next    = frames;
    ch_state_next  = '0;
    if (!tdd_enable) begin
      state_next     = ST_IDLE;
      counter_next   = '0;
      delay_cnt_next = '0;
      frames_next    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (trig) begin
            counter_next   = '0;
            delay_cnt_next = '0;
            frames_next    = '0;
            state_next     = (tdd_startup_delay == '0) ? ST_RUNNING : ST_WAITING;
          end
        end
        ST_WAITING: begin
          if (delay_cnt == tdd_startup_delay - REGISTER_WIDTH'(1)) begin
            state_next     = ST_RUNNING;
            counter_next   = '0;
            delay_cnt_next = '0;
          end else begin
            delay_cnt_next = delay_cnt + REGISTER_WIDTH'(1);
          end
        end
        ST_RUNNING: begin
          if (tdd_sync_rst && trig) begin
            counter_next = '0;
            frames_next  = '0;
          end else begin
            ch_state_next = ch_match;
            if (last_cycle) begin
              counter_next = '0;
              if ((tdd_burst_count != '0) && (frames + BURST_WIDTH'(1) == tdd_burst_count)) begin
                state_next    = ST_ARMED;
                frames_next   = '0;
                ch_state_next = '0;
              end else begin
                frames_next = frames + BURST_WIDTH'(1);
              end
            end else begin
              counter_next = counter + REGISTER_WIDTH'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register plus registered outputs; EOF is aligned with the counter showing frame_length.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      counter         <= '0;
      delay_cnt       <= '0;
      frames          <= '0;
      ch_state        <= '0;
      sync_ext_d      <= 1'b0;
      tdd_endof_frame <= 1'b0;
      tdd_channel     <= '0;
    end else begin
      state           <= state_next;
      counter         <= counter_next;
      delay_cnt       <= delay_cnt_next;
      frames          <= frames_next;
      ch_state        <= ch_state_next;
      sync_ext_d      <= tdd_sync_ext;
      tdd_endof_frame <= (state_next == ST_RUNNING) && (counter_next == tdd_frame_length);
      tdd_channel     <= (ch_state_next & tdd_channel_en) ^ tdd_channel_pol;
    end
  end

endmodule
